ising_energy_evaluator: RTL and testbench

- Downstream stage of the oscillator Ising solver. Consumes the final oscillator phases and the same coupling matrix used by the solver.
- Binarises each phase to a spin s_i in {+1,-1}.
- Sequentially accumulates the Ising energy E = -sum over i<j of J_ij*s_i*s_j, one pair per cycle.
- Reports E plus the spin vector so a host or annealing controller can score each run.

---
 rtl/ising_pkg.sv | 21 ++
 rtl/ising_energy_evaluator_binarizer.sv | 32 +++
 rtl/ising_energy_evaluator.sv | 181 ++++++++++++++++++
 tb/tb_ising_energy_evaluator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared types and constants for the oscillator Ising solver and its
// energy evaluator: FSM state encoding, Q16.16 angle constants, widths.
package ising_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BINARIZE,
        ACCUM,
        FINISH
    } state_t;

    // round(2^16 / (2*pi)) and round(pi * 2^16) for Q16.16
    localparam int INV_TWO_PI_Q = 10430;
    localparam int PI_Q         = 205887;

    // Energy accumulator width: one entry plus headroom for N^2 terms
    function automatic int acc_width(input int n, input int dw);
        return dw + 2 * $clog2(n);
    endfunction

endpackage

// File: rtl/ising_energy_evaluator_binarizer.sv
// phase_binarizer: combinational phase-to-spin for one oscillator.
// Ports: phase (signed Q.fractionalBits radians) -> spin (1 = +1, 0 = -1).
module phase_binarizer
    import ising_pkg::*;
#(
    parameter int dataWidth      = 32,
    parameter int fractionalBits = 16
) (
    input  logic signed [dataWidth-1:0] phase,
    output logic                        spin
);

    localparam int PW = 2 * dataWidth;
    localparam logic signed [PW-1:0] INV = PW'(INV_TWO_PI_Q);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] turns;
    logic        [1:0]    q;
    logic                 unused_bits;

    assign prod  = PW'(phase) * INV;
    assign turns = prod >>> fractionalBits;

    // Top two fractional bits of "turns" give the quadrant modulo 2*pi,
    // so any signed phase wraps naturally.
    assign q     = turns[fractionalBits-1 -: 2];
    assign spin  = (q == 2'b00) || (q == 2'b11);

    assign unused_bits = ^{turns[PW-1:fractionalBits],
                           turns[fractionalBits-3:0]};

endmodule

// File: rtl/ising_energy_evaluator.sv
// Ising energy evaluator: binarises oscillator phases to spins and
// accumulates E = -sum_{i<j} J_ij*s_i*s_j one pair per clock.
// Ports: clk, n_rst (async low), start, phases[N], couplingMatrix[N][N]
//   -> busy, done (pulse), spins[N-1:0], energy (signed ACC_W).
// Option ISING_BEST_TRACK_EN: clear_best in, best_energy/best_spins out.
module ising_energy_evaluator
    import ising_pkg::*;
#(
    parameter int N              = 16,
    parameter int fractionalBits = 16,
    parameter int dataWidth      = 32,
    parameter int ACC_W          = acc_width(N, dataWidth)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic signed [dataWidth-1:0] phases         [N],
    input  logic signed [dataWidth-1:0] couplingMatrix [N][N],
`ifdef ISING_BEST_TRACK_EN
    input  logic                        clear_best,
    output logic signed [ACC_W-1:0]     best_energy,
    output logic        [N-1:0]         best_spins,
`endif
    output logic                        busy,
    output logic                        done,
    output logic        [N-1:0]         spins,
    output logic signed [ACC_W-1:0]     energy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_J = IW'(N - 1);
    localparam logic [IW-1:0] LAST_I = IW'(N - 2);

    state_t                       state_q, state_d;
    logic signed [dataWidth-1:0]  ph_q [N];
    logic signed [dataWidth-1:0]  ph_d [N];
    logic        [N-1:0]          sv_q, sv_d;
    logic        [N-1:0]          spin_w;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic        [IW-1:0]         i_q, i_d, j_q, j_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic        [N-1:0]          spins_q, spins_d;
    logic signed [ACC_W-1:0]      energy_q, energy_d;
    logic signed [dataWidth-1:0]  jij;
    logic signed [ACC_W-1:0]      jx;
    logic                         same;

    for (genvar g = 0; g < N; g++) begin : g_bin
        phase_binarizer #(
            .dataWidth      (dataWidth),
            .fractionalBits (fractionalBits)
        ) u_bin (
            .phase (ph_q[g]),
            .spin  (spin_w[g])
        );
    end

    assign jij  = couplingMatrix[i_q][j_q];
    assign jx   = ACC_W'(jij);
    assign same = (sv_q[i_q] == sv_q[j_q]);

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        sv_d     = sv_q;
        acc_d    = acc_q;
        i_d      = i_q;
        j_d      = j_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        spins_d  = spins_q;
        energy_d = energy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ph_d    = phases;
                    busy_d  = 1'b1;
                    state_d = BINARIZE;
                end
            end
            BINARIZE: begin
                sv_d  = spin_w;
                acc_d = '0;
                i_d   = '0;
                j_d   = IW'(1);
                if (N == 1) begin
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = same ? acc_q - jx : acc_q + jx;
                if (j_q == LAST_J) begin
                    i_d = i_q + IW'(1);
                    j_d = i_q + IW'(2);
                end else begin
                    j_d = j_q + IW'(1);
                end
                if (i_q == LAST_I && j_q == LAST_J) begin
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                energy_d = acc_q;
                spins_d  = sv_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            for (int k = 0; k < N; k++) ph_q[k] <= '0;
            sv_q     <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= IW'(1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            spins_q  <= '0;
            energy_q <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            sv_q     <= sv_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            j_q      <= j_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            spins_q  <= spins_d;
            energy_q <= energy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign spins  = spins_q;
    assign energy = energy_q;

`ifdef ISING_BEST_TRACK_EN
    localparam logic signed [ACC_W-1:0] E_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic signed [ACC_W-1:0] best_e_q, best_e_d;
    logic        [N-1:0]     best_s_q, best_s_d;

    // Clear has priority over recording the result finishing this cycle.
    always_comb begin
        best_e_d = best_e_q;
        best_s_d = best_s_q;
        if (clear_best) begin
            best_e_d = E_MAX;
            best_s_d = '0;
        end else if (state_q == FINISH && acc_q < best_e_q) begin
            best_e_d = acc_q;
            best_s_d = sv_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            best_e_q <= E_MAX;
            best_s_q <= '0;
        end else begin
            best_e_q <= best_e_d;
            best_s_q <= best_s_d;
        end
    end

    assign best_energy = best_e_q;
    assign best_spins  = best_s_q;
`endif

endmodule

// File: tb/tb_ising_energy_evaluator.sv
// Scoreboard bench for ising_energy_evaluator at N=4, Q16.16.
// Honours ISING_BEST_TRACK_EN for the best-result tracking checks.
module tb_ising_energy_evaluator;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FB = 16;
    localparam int AW = 36;
    localparam logic signed [63:0] E_MAX = 64'sd34359738367;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [DW-1:0] ph [N];
    logic signed [DW-1:0] cm [N][N];
    logic                 busy, done;
    logic        [N-1:0]  spins;
    logic signed [AW-1:0] energy;
`ifdef ISING_BEST_TRACK_EN
    logic                 clear_best = 1'b0;
    logic signed [AW-1:0] best_energy;
    logic        [N-1:0]  best_spins;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        [N-1:0]  s;
        logic signed [AW-1:0] e;
        int                   at;
    } exp_t;
    exp_t sb [$];

    ising_energy_evaluator #(
        .N              (N),
        .fractionalBits (FB),
        .dataWidth      (DW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .phases         (ph),
        .couplingMatrix (cm),
`ifdef ISING_BEST_TRACK_EN
        .clear_best     (clear_best),
        .best_energy    (best_energy),
        .best_spins     (best_spins),
`endif
        .busy           (busy),
        .done           (done),
        .spins          (spins),
        .energy         (energy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("energy", energy, e.e);
                chk("spins", spins, e.s);
                chk("done_latency", cyc, e.at);
            end
        end
    end

    task automatic set_j(input logic signed [DW-1:0] up,
                         input logic signed [DW-1:0] lo,
                         input logic signed [DW-1:0] dg);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cm[r][c] = (c > r) ? up : ((c < r) ? lo : dg);
    endtask

    task automatic set_ph(input logic signed [DW-1:0] p0,
                          input logic signed [DW-1:0] p1,
                          input logic signed [DW-1:0] p2,
                          input logic signed [DW-1:0] p3);
        ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
    endtask

    task automatic run(input logic [N-1:0] es, input logic signed [AW-1:0] ee,
                       input bit repulse);
        int  k;
        int  bc;
        bit  seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
        e.s = es;
        e.e = ee;
        e.at = k + 8;
        sb.push_back(e);
        bc = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) seen = 1'b1;
            start = repulse && (cyc == k + 2 || cyc == k + 4);
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got none expected done by %0d", k + 8);
        end
        chk("busy_cycles", bc, 7);
        repeat (3) @(negedge clk);
    endtask

`ifdef ISING_BEST_TRACK_EN
    task automatic chk_best(input logic signed [63:0] e, input logic [N-1:0] s);
        chk("best_energy", best_energy, e);
        chk("best_spins", best_spins, s);
    endtask
`endif

    initial begin
        int  k;
        bit  saw;
        set_ph(0, 0, 0, 0);
        set_j(32'sh00010000, 32'sh00010000, 32'sh00010000);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spins", spins, 0);
        chk("rst_energy", energy, 0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(E_MAX, '0);
`endif
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        run(4'b1111, -36'sd393216, 1'b0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(-393216, 4'b1111);
`endif

        set_ph(205887, 0, 0, 0);
        run(4'b1110, 36'sd0, 1'b0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(-393216, 4'b1111);
`endif

        set_ph(0, 0, 0, 0);
        run(4'b1111, -36'sd393216, 1'b1);
`ifdef ISING_BEST_TRACK_EN
        chk_best(-393216, 4'b1111);
        @(negedge clk);
        clear_best = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        chk_best(E_MAX, '0);
`endif

        set_ph(-51472, 154415, 411775, -154415);
        run(4'b0101, 36'sd131072, 1'b0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(131072, 4'b0101);
`endif

        set_ph(0, 0, 0, 0);
        set_j(32'sh00020000, 32'sh7FFFFFFF, 32'sh7FFFFFFF);
        run(4'b1111, -36'sd786432, 1'b0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(-786432, 4'b1111);
`endif

        // Abort a run during its third accumulation cycle.
        set_j(32'sh00010000, 32'sh00010000, 32'sh00010000);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
        for (int c = 0; c < 20 && cyc < k + 3; c++) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_spins", spins, 0);
        chk("abort_energy", energy, 0);
`ifdef ISING_BEST_TRACK_EN
        chk_best(E_MAX, '0);
`endif
        @(negedge clk);
        n_rst = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("no_done_after_abort", saw, 0);

        run(4'b1111, -36'sd393216, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
